btn_input_conditioner: RTL and testbench

//  Front end of the player-input path: synchronises and debounces the four raw board

---
 rtl/btn_input_conditioner.sv | 152 +++++++++++++++
 tb/tb_btn_input_conditioner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_input_conditioner.sv
// btn_input_conditioner: synchronises and debounces four push-buttons and derives a one-hot direction request.
// Optional build macro BTN_STICKY_DIR_EN: after the last held button is released, dir_req keeps the last nonzero direction.
module btn_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rbtn_raw,
  input  logic       lbtn_raw,
  input  logic       ubtn_raw,
  input  logic       dbtn_raw,
  output logic       rbtn,
  output logic       lbtn,
  output logic       ubtn,
  output logic       dbtn,
  output logic [3:0] dir_req,
  output logic       dir_valid,
  output logic       any_btn
);
  localparam logic [1:0] S_IDLE_LO = 2'd0;
  localparam logic [1:0] S_WAIT_HI = 2'd1;
  localparam logic [1:0] S_IDLE_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;
  // The idle cycle that first sees the new value is the first stable cycle, so the
  // wait state accepts after DEBOUNCE_CYCLES-1 further stable cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [3:0] w_raw;
  logic [3:0] w_lvl;
  logic [3:0] w_lvl_nxt;
  logic [3:0] w_rise;
  logic [3:0] w_fall;
  logic [3:0] w_fallback;
  logic [3:0] w_dir_nxt;
  logic [3:0] r_dir;
  logic       r_valid;
  logic       r_any;

  // Isolates the lowest set bit, i.e. the highest-priority button (right is bit 0).
  function automatic logic [3:0] f_first(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  assign w_raw = {dbtn_raw, ubtn_raw, lbtn_raw, rbtn_raw};

  for (genvar b = 0; b < 4; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_lvl;
    logic                   w_lvl_b;
    logic                   w_s;

    assign w_s          = r_sync[SYNC_STAGES-1];
    assign w_lvl[b]     = r_lvl;
    assign w_lvl_nxt[b] = w_lvl_b;

    // Shift the asynchronous raw button through the synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_sync <= '0;
      else      r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[b]};
    end

    // Debounce FSM: a change is accepted only after the synchronised input holds it long enough.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      w_lvl_b     = r_lvl;
      case (r_state)
        S_IDLE_LO: begin
          w_state_nxt = w_s ? S_WAIT_HI : S_IDLE_LO;
          w_cnt_nxt   = '0;
        end
        S_WAIT_HI: begin
          if (!w_s) begin
            w_state_nxt = S_IDLE_LO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_IDLE_HI;
            w_cnt_nxt   = '0;
            w_lvl_b     = 1'b1;
          end
        end
        S_IDLE_HI: begin
          w_state_nxt = w_s ? S_IDLE_HI : S_WAIT_LO;
          w_cnt_nxt   = '0;
        end
        default: begin
          if (w_s) begin
            w_state_nxt = S_IDLE_HI;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_IDLE_LO;
            w_cnt_nxt   = '0;
            w_lvl_b     = 1'b0;
          end
        end
      endcase
    end

    // Register FSM state, debounce count and the clean level.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= S_IDLE_LO;
        r_cnt   <= '0;
        r_lvl   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_lvl   <= w_lvl_b;
      end
    end
  end

  assign w_rise = w_lvl_nxt & ~w_lvl;
  assign w_fall = w_lvl & ~w_lvl_nxt;

`ifdef BTN_STICKY_DIR_EN
  assign w_fallback = (|w_lvl_nxt) ? f_first(w_lvl_nxt) : r_dir;
`else
  assign w_fallback = f_first(w_lvl_nxt);
`endif

  // A new press wins; releasing the current direction falls back to what is still held.
  assign w_dir_nxt = (|w_rise) ? f_first(w_rise) : (|(w_fall & r_dir)) ? w_fallback : r_dir;

  // Register direction, its change pulse and the any-button flag alongside the levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir   <= 4'b0000;
      r_valid <= 1'b0;
      r_any   <= 1'b0;
    end else begin
      r_dir   <= w_dir_nxt;
      r_valid <= (w_dir_nxt != r_dir) && (|w_dir_nxt);
      r_any   <= |w_lvl_nxt;
    end
  end

  assign rbtn      = w_lvl[0];
  assign lbtn      = w_lvl[1];
  assign ubtn      = w_lvl[2];
  assign dbtn      = w_lvl[3];
  assign dir_req   = r_dir;
  assign dir_valid = r_valid;
  assign any_btn   = r_any;
endmodule

// File: tb/tb_btn_input_conditioner.sv
// tb_btn_input_conditioner: directed and randomized checks against a stability-run reference model.
module tb_btn_input_conditioner;
  localparam int DEB = 4;
`ifdef BTN_STICKY_DIR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = 4'b0000;
  logic       rbtn, lbtn, ubtn, dbtn, dir_valid, any_btn;
  logic [3:0] dir_req;
  logic [9:0] obs, exp_v;
  int vectors = 0;
  int miscompares = 0;

  logic [3:0] m_d0 = '0, m_d1 = '0, m_lvl = '0, m_dir = '0;
  logic       m_valid = 1'b0, m_any = 1'b0;
  int         m_run [4] = '{0, 0, 0, 0};

  btn_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(20), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .rbtn_raw(raw[0]), .lbtn_raw(raw[1]), .ubtn_raw(raw[2]), .dbtn_raw(raw[3]),
    .rbtn(rbtn), .lbtn(lbtn), .ubtn(ubtn), .dbtn(dbtn),
    .dir_req(dir_req), .dir_valid(dir_valid), .any_btn(any_btn)
  );

  always #5 clk = ~clk;

  assign obs   = {dbtn, ubtn, lbtn, rbtn, dir_req, dir_valid, any_btn};
  assign exp_v = {m_lvl, m_dir, m_valid, m_any};

  function automatic logic [3:0] first_held(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  // Reference: each button delays its raw sample by two clocks, then flips its level once
  // that delayed sample has differed from the level for DEB consecutive clocks.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_d0 <= '0; m_d1 <= '0; m_lvl <= '0; m_dir <= '0; m_valid <= 1'b0; m_any <= 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] <= 0;
    end else begin : upd
      logic [3:0] nl, ris, fal, nd;
      int r;
      nl = m_lvl;
      for (int i = 0; i < 4; i++) begin
        r = (m_d1[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
        if (r == DEB) begin
          nl[i] = m_d1[i];
          r = 0;
        end
        m_run[i] <= r;
      end
      ris = nl & ~m_lvl;
      fal = m_lvl & ~nl;
      nd = m_dir;
      if (ris != 0) nd = first_held(ris);
      else if ((fal & m_dir) != 0) nd = (nl != 0) ? first_held(nl) : (STICKY ? m_dir : 4'b0000);
      m_valid <= (nd != m_dir) && (nd != 0);
      m_dir <= nd;
      m_any <= (nl != 0);
      m_lvl <= nl;
      m_d1 <= m_d0;
      m_d0 <= raw;
    end
  end

  task automatic reset_dut;
    raw = 4'b0000;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    int k_rise;
    k_rise = 0;
    raw = 4'b1111;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== 10'd0) begin miscompares++; $display("FAIL reset_state: got %b want %b", obs, 10'd0); end
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL reset_release c%0d: got %b want %b", k, obs, exp_v); end
      if (rbtn && k_rise == 0) k_rise = k;
    end
    vectors++;
    if (k_rise !== 6) begin miscompares++; $display("FAIL reset_latency: got %0d want 6", k_rise); end
    raw = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL reset_drop c%0d: got %b want %b", k, obs, exp_v); end
    end
  endtask

  task automatic test_press;
    int k_rise, pulses;
    k_rise = 0;
    pulses = 0;
    reset_dut();
    raw = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL press c%0d: got %b want %b", k, obs, exp_v); end
      if (rbtn && k_rise == 0) begin
        k_rise = k;
        vectors++;
        if ({dir_req, dir_valid} !== 5'b0001_1) begin
          miscompares++; $display("FAIL press_dir: got %b%b want 00011", dir_req, dir_valid);
        end
      end
      pulses += int'(dir_valid);
    end
    vectors++;
    if (k_rise !== 6) begin miscompares++; $display("FAIL press_latency: got %0d want 6", k_rise); end
    vectors++;
    if (pulses !== 1) begin miscompares++; $display("FAIL press_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_glitch;
    int k_rise, rises, pulses;
    logic prev;
    k_rise = 0;
    rises = 0;
    pulses = 0;
    prev = 1'b0;
    reset_dut();
    for (int c = 0; c < 12; c++) begin
      raw = {1'b0, ((c / 2) % 2 == 0), 2'b00};
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL glitch c%0d: got %b want %b", c, obs, exp_v); end
      rises += int'(ubtn && !prev);
      prev = ubtn;
      pulses += int'(dir_valid);
    end
    raw = 4'b0100;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL glitch_hold c%0d: got %b want %b", k, obs, exp_v); end
      if (ubtn && !prev) begin
        rises++;
        if (k_rise == 0) k_rise = k;
      end
      prev = ubtn;
      pulses += int'(dir_valid);
    end
    vectors++;
    if (k_rise !== 6) begin miscompares++; $display("FAIL glitch_latency: got %0d want 6", k_rise); end
    vectors++;
    if (rises !== 1 || pulses !== 1) begin
      miscompares++; $display("FAIL glitch_count: got rises=%0d pulses=%0d want 1/1", rises, pulses);
    end
  endtask

  task automatic test_direction;
    logic [3:0] stim [4];
    logic [3:0] want_dir [4];
    int want_pulse [4];
    int pulses;
    stim = '{4'b0001, 4'b0101, 4'b0001, 4'b0000};
    want_dir = '{4'b0001, 4'b0100, 4'b0001, STICKY ? 4'b0001 : 4'b0000};
    want_pulse = '{1, 1, 1, 0};
    reset_dut();
    for (int p = 0; p < 4; p++) begin
      pulses = 0;
      raw = stim[p];
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL dir_ph%0d c%0d: got %b want %b", p, k, obs, exp_v); end
        pulses += int'(dir_valid);
      end
      vectors++;
      if (dir_req !== want_dir[p] || pulses !== want_pulse[p]) begin
        miscompares++;
        $display("FAIL dir_phase%0d: got dir=%b pulses=%0d want dir=%b pulses=%0d", p, dir_req, pulses, want_dir[p], want_pulse[p]);
      end
    end
  endtask

  task automatic test_simultaneous;
    int pulses;
    pulses = 0;
    reset_dut();
    raw = 4'b1010;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL simul c%0d: got %b want %b", k, obs, exp_v); end
      pulses += int'(dir_valid);
    end
    vectors++;
    if ({lbtn, dbtn, dir_req} !== 6'b11_0010 || pulses !== 1) begin
      miscompares++; $display("FAIL simul_final: got l=%b d=%b dir=%b pulses=%0d want 1 1 0010 1", lbtn, dbtn, dir_req, pulses);
    end
  endtask

  task automatic test_reset_mid;
    int k_rise;
    k_rise = 0;
    reset_dut();
    raw = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL rstmid_pre c%0d: got %b want %b", k, obs, exp_v); end
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== 10'd0) begin miscompares++; $display("FAIL rstmid_clear: got %b want %b", obs, 10'd0); end
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL rstmid c%0d: got %b want %b", k, obs, exp_v); end
      if (rbtn && k_rise == 0) k_rise = k;
    end
    vectors++;
    if (k_rise !== 6) begin miscompares++; $display("FAIL rstmid_latency: got %0d want 6", k_rise); end
  endtask

  task automatic test_random;
    int hold;
    reset_dut();
    for (int n = 0; n < 120; n++) begin
      raw = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 2 * DEB);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL random n%0d c%0d: got %b want %b", n, k, obs, exp_v); end
      end
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_press();
    test_glitch();
    test_direction();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
